fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the decoder/control unit.
- Generates the PC and runs a request/grant/response handshake to instruction memory with at most one request outstanding.
- Holds one fetched instruction in IF/ID, with a one-entry skid buffer, under decode stalls.
- Applies branch/jump redirects and exports the opcode and funct fields to the control unit, forcing a bubble opcode when IF/ID is empty.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fetch_skid.sv | 54 +++++
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, instruction field geometry and
// the fetch-stage request state.
package cpu_pkg;

    localparam logic [2:0] OP_RTYPE  = 3'b000;
    localparam logic [2:0] OP_XORI   = 3'b001;
    localparam logic [2:0] OP_BEQ    = 3'b010;
    localparam logic [2:0] OP_BGT    = 3'b011;
    localparam logic [2:0] OP_SW     = 3'b100;
    localparam logic [2:0] OP_LW     = 3'b101;
    localparam logic [2:0] OP_J      = 3'b110;
    localparam logic [2:0] OP_BUBBLE = 3'b111;

    // Opcode occupies the top OPC_W bits of the instruction; funct the low bits.
    localparam int OPC_W     = 3;
    localparam int FUNCT_W   = 4;
    localparam int FUNCT_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// One-entry {instr, pc} holding register that catches a fetch response
// arriving while IF/ID is stalled.
module fetch_skid #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               drain_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with a single-outstanding imem handshake, IF/ID register
// backed by a one-entry skid, and redirect flush/refetch.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_gnt_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               if_id_valid_o,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic [ADDR_W-1:0]  if_id_pc_o,
    output logic [ADDR_W-1:0]  if_id_pc4_o,
    output logic [2:0]         opcode_o,
    output logic [3:0]         funct_o
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;

    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;

    logic can_load, consume, resp_ok, resp_load, skid_load, skid_drain;

    assign can_load   = !if_id_valid_q || !stall_i;
    assign consume    = if_id_valid_q && !stall_i;
    assign resp_ok    = (state_q == WAIT) && imem_rvalid_i && !redirect_i;
    assign resp_load  = resp_ok && can_load;
    assign skid_load  = resp_ok && !can_load;
    assign skid_drain = skid_valid && can_load && !redirect_i;

    // Gating with rst_n keeps the request low for the whole reset window;
    // requiring an empty skid guarantees a response never meets a full skid.
    assign imem_req_o  = rst_n && (state_q == IDLE) && !skid_valid && !redirect_i;
    assign imem_addr_o = pc_q;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        if_id_valid_d = if_id_valid_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if (redirect_i) begin
            pc_d          = redirect_pc_i & WORD_MASK;
            if_id_valid_d = 1'b0;
            if (state_q != IDLE) begin
                state_d = imem_rvalid_i ? IDLE : DROP;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (imem_req_o && imem_gnt_i) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + ADDR_W'(4);
                        state_d  = WAIT;
                    end
                end
                WAIT, DROP: begin
                    if (imem_rvalid_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (resp_load) begin
                if_id_valid_d = 1'b1;
                if_id_instr_d = imem_rdata_i;
                if_id_pc_d    = req_pc_q;
            end else if (skid_drain) begin
                if_id_valid_d = 1'b1;
                if_id_instr_d = skid_instr;
                if_id_pc_d    = skid_pc;
            end else if (consume) begin
                if_id_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            req_pc_q      <= '0;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= '0;
            if_id_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            if_id_valid_q <= if_id_valid_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
        end
    end

    fetch_skid #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (skid_load),
        .drain_i(skid_drain),
        .flush_i(redirect_i),
        .instr_i(imem_rdata_i),
        .pc_i   (req_pc_q),
        .valid_o(skid_valid),
        .instr_o(skid_instr),
        .pc_o   (skid_pc)
    );

    assign if_id_valid_o = if_id_valid_q;
    assign if_id_instr_o = if_id_instr_q;
    assign if_id_pc_o    = if_id_pc_q;
    assign if_id_pc4_o   = if_id_pc_q + ADDR_W'(4);
    assign opcode_o      = if_id_valid_q ? if_id_instr_q[INSTR_W-1 -: OPC_W] : OP_BUBBLE;
    assign funct_o       = if_id_valid_q ? if_id_instr_q[FUNCT_LSB +: FUNCT_W] : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a memory responder, a scripted stimulus
// sequence and a scoreboard monitor checking every instruction decode consumes.
module tb_fetch_stage;
    import cpu_pkg::*;

    localparam int AW = 32;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_gnt_i;
    logic          imem_rvalid_i;
    logic [IW-1:0] imem_rdata_i;
    logic          stall_i;
    logic          redirect_i;
    logic [AW-1:0] redirect_pc_i;
    logic          if_id_valid_o;
    logic [IW-1:0] if_id_instr_o;
    logic [AW-1:0] if_id_pc_o;
    logic [AW-1:0] if_id_pc4_o;
    logic [2:0]    opcode_o;
    logic [3:0]    funct_o;

    fetch_stage #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .if_id_valid_o(if_id_valid_o), .if_id_instr_o(if_id_instr_o),
        .if_id_pc_o(if_id_pc_o), .if_id_pc4_o(if_id_pc4_o),
        .opcode_o(opcode_o), .funct_o(funct_o)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
        logic [2:0]    opc;
        logic [3:0]    funct;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_tot  = 0;
    int   lat    = 1;
    int   cyc    = 0;

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic push(input logic [AW-1:0] pc, input logic [IW-1:0] instr,
                        input logic [2:0] opc, input logic [3:0] funct);
        exp_t e;
        e.pc = pc; e.instr = instr; e.opc = opc; e.funct = funct;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    // Memory: word at addr is {addr[4:2], 5'b0, addr[23:0]}, returned lat cycles after grant.
    initial begin
        logic          gnow;
        logic [AW-1:0] gaddr;
        logic [AW-1:0] raddr;
        int            cnt;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        raddr = '0;
        cnt   = 0;
        forever begin
            @(negedge clk);
            gnow  = imem_req_o && imem_gnt_i;
            gaddr = imem_addr_o;
            @(posedge clk); #1;
            imem_rvalid_i = 1'b0;
            if (gnow) begin
                cnt   = lat;
                raddr = gaddr;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = {raddr[4:2], 5'b0, raddr[23:0]};
                end
            end
        end
    end

    // Monitor: every instruction consumed by decode must match the next expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (if_id_valid_o) begin
                    if (!stall_i) begin
                        if (sb.size() == 0) begin
                            n_tot++;
                            $display("FAIL unexpected_instr: pc 0x%08h instr 0x%08h, none expected",
                                     if_id_pc_o, if_id_instr_o);
                        end else begin
                            e = sb.pop_front();
                            check("if_id_pc", if_id_pc_o, e.pc);
                            check("if_id_instr", if_id_instr_o, e.instr);
                            check("if_id_pc4", if_id_pc4_o, e.pc + 32'd4);
                            check("opcode", 32'(opcode_o), 32'(e.opc));
                            check("funct", 32'(funct_o), 32'(e.funct));
                        end
                    end
                end else begin
                    check("bubble_opcode", 32'(opcode_o), 32'(OP_BUBBLE));
                    check("bubble_funct", 32'(funct_o), 32'h0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_tot);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; imem_gnt_i = 1'b0; stall_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(imem_req_o), 32'h0);
        check("rst_valid", 32'(if_id_valid_o), 32'h0);
        check("rst_instr", if_id_instr_o, 32'h0);
        check("rst_pc", if_id_pc_o, 32'h0);
        check("rst_opcode", 32'(opcode_o), 32'h7);

        // Streaming fetch 0,4,8 then the stalled 12
        push(32'h00, 32'h0000_0000, 3'b000, 4'h0);
        push(32'h04, 32'h2000_0004, 3'b001, 4'h4);
        push(32'h08, 32'h4000_0008, 3'b010, 4'h8);
        push(32'h0C, 32'h6000_000C, 3'b011, 4'hC);
        @(posedge clk); #1;
        rst_n = 1'b1; imem_gnt_i = 1'b1; cyc = 0;
        @(negedge clk);
        check("first_req", 32'(imem_req_o), 32'h1);
        check("first_addr", imem_addr_o, 32'h0);

        // Stall while the response for 12 returns: it lands in the skid
        go_to(6); stall_i = 1'b1;
        go_to(8); @(negedge clk);
        check("stall_no_req", 32'(imem_req_o), 32'h0);
        check("stall_hold_valid", 32'(if_id_valid_o), 32'h1);
        check("stall_hold_pc", if_id_pc_o, 32'h08);
        go_to(11); stall_i = 1'b0;
        push(32'h10, 32'h8000_0010, 3'b100, 4'h0);
        go_to(12); @(negedge clk);
        check("skid_out_valid", 32'(if_id_valid_o), 32'h1);
        check("skid_out_pc", if_id_pc_o, 32'h0C);

        // Redirect while WAIT, stale response 3 cycles after grant
        go_to(14); lat = 3;
        go_to(15); redirect_i = 1'b1; redirect_pc_i = 32'h40;
        go_to(16); redirect_i = 1'b0; lat = 1;
        @(negedge clk);
        check("redir_drop_state", 32'(dut.state_q), 32'(DROP));
        check("redir_drop_noreq", 32'(imem_req_o), 32'h0);
        push(32'h40, 32'h0000_0040, 3'b000, 4'h0);
        push(32'h44, 32'h2000_0044, 3'b001, 4'h4);
        go_to(17); @(negedge clk);
        check("drop_state_hold", 32'(dut.state_q), 32'(DROP));
        go_to(18); @(negedge clk);
        check("redir_req", 32'(imem_req_o), 32'h1);
        check("redir_addr", imem_addr_o, 32'h40);

        // Redirect coinciding with rvalid, unaligned target
        go_to(23); redirect_i = 1'b1; redirect_pc_i = 32'h83;
        go_to(24); redirect_i = 1'b0; imem_gnt_i = 1'b0;
        @(negedge clk);
        check("redir2_state", 32'(dut.state_q), 32'(IDLE));
        check("redir2_addr", imem_addr_o, 32'h80);
        push(32'h80, 32'h0000_0080, 3'b000, 4'h0);

        // Grant withheld: request and address hold, pc does not advance
        for (int c = 24; c < 28; c++) begin
            go_to(c); @(negedge clk);
            check("nogrant_req", 32'(imem_req_o), 32'h1);
            check("nogrant_addr", imem_addr_o, 32'h80);
            check("nogrant_pc", dut.pc_q, 32'h80);
        end
        go_to(28); imem_gnt_i = 1'b1;
        go_to(29); @(negedge clk);
        check("grant_pc_adv", dut.pc_q, 32'h84);
        check("grant_state", 32'(dut.state_q), 32'(WAIT));

        // Reset mid-WAIT with IF/ID holding 0x84 under stall
        go_to(32); stall_i = 1'b1; lat = 3;
        go_to(33);
        check("pre_rst_valid", 32'(if_id_valid_o), 32'h1);
        rst_n = 1'b0; #1;
        check("mid_rst_valid", 32'(if_id_valid_o), 32'h0);
        check("mid_rst_instr", if_id_instr_o, 32'h0);
        check("mid_rst_pc", if_id_pc_o, 32'h0);
        check("mid_rst_req", 32'(imem_req_o), 32'h0);
        check("mid_rst_opcode", 32'(opcode_o), 32'h7);
        push(32'h00, 32'h0000_0000, 3'b000, 4'h0);
        go_to(35); rst_n = 1'b1; stall_i = 1'b0; lat = 1;
        @(negedge clk);
        check("rel_req", 32'(imem_req_o), 32'h1);
        check("rel_addr", imem_addr_o, 32'h0);
        check("rel_valid", 32'(if_id_valid_o), 32'h0);
        go_to(36); imem_gnt_i = 1'b0;
        go_to(37); @(negedge clk);
        check("rel_first_valid", 32'(if_id_valid_o), 32'h1);
        go_to(42); @(negedge clk);
        check("end_req_addr", imem_addr_o, 32'h4);
        check("end_pc", dut.pc_q, 32'h4);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
